// File: rtl/sequence_generator.sv
// Serial burst generator: sends rep+1 back-to-back frames of a latched pattern, MSB first.
// Optional macro SEQGEN_PARITY_EN appends an even-parity bit to every frame.
module sequence_generator #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] DEF_PAT = WIDTH'(4'b1011)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             use_def,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       rep,
    output logic             q,
    output logic             valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQGEN_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = $clog2(FLEN);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

`ifdef SEQGEN_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] pat);
        return ^pat;
    endfunction
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [3:0]       rem_q, rem_d;
    logic             q_q, q_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sel_pat_s;

    assign sel_pat_s = use_def ? DEF_PAT : pattern;

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        rem_d   = rem_q;
        q_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    state_d = ST_SHIFT;
                    pat_d   = sel_pat_s;
                    sh_d    = sel_pat_s;
                    rem_d   = rep;
                    bit_d   = {CW{1'b0}};
                    q_d     = sel_pat_s[WIDTH-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_q == CW'(FLEN - 1)) begin
                    if (rem_q == 4'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d   = rem_q - 4'd1;
                        bit_d   = {CW{1'b0}};
                        sh_d    = pat_q;
                        q_d     = pat_q[WIDTH-1];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    bit_d   = bit_q + CW'(1);
                    sh_d    = {sh_q[WIDTH-2:0], 1'b0};
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef SEQGEN_PARITY_EN
                    // The slot after the last data bit carries the frame parity.
                    if (bit_d == CW'(WIDTH)) begin
                        q_d = even_parity(pat_q);
                    end else begin
                        q_d = sh_d[WIDTH-1];
                    end
`else
                    q_d = sh_d[WIDTH-1];
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= {WIDTH{1'b0}};
            sh_q    <= {WIDTH{1'b0}};
            bit_q   <= {CW{1'b0}};
            rem_q   <= 4'd0;
            q_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sequence_generator;

    localparam int         W   = 4;
    localparam logic [3:0] DEF = 4'b1011;
`ifdef SEQGEN_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       use_def = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic [3:0] rep = 4'd0;
    logic       q, valid, busy, done;

    int checks = 0;
    int failures = 0;

    sequence_generator dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .use_def(use_def),
        .pattern(pattern), .rep(rep), .q(q), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of the bits still to be sent; head is the bit on q.
    bit   mq[$];
    logic exp_q = 1'b0, exp_v = 1'b0, exp_b = 1'b0, exp_d = 1'b0;

    always @(posedge clk) begin
        logic [3:0] p;
        exp_q = 1'b0; exp_v = 1'b0; exp_b = 1'b0; exp_d = 1'b0;
        if (!rst) begin
            mq.delete();
        end else if (mq.size() != 0) begin
            if (abort) begin
                mq.delete();
            end else begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    exp_d = 1'b1;
                end else begin
                    exp_q = mq[0]; exp_v = 1'b1; exp_b = 1'b1;
                end
            end
        end else if (start && !abort) begin
            p = use_def ? DEF : pattern;
            for (int f = 0; f <= int'(rep); f++) begin
                for (int i = W - 1; i >= 0; i--) mq.push_back(p[i]);
`ifdef SEQGEN_PARITY_EN
                mq.push_back(^p);
`endif
            end
            exp_q = mq[0]; exp_v = 1'b1; exp_b = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Advance one clock, then compare every output against the model away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("q", {31'd0, q}, {31'd0, exp_q});
        chk("valid", {31'd0, valid}, {31'd0, exp_v});
        chk("busy", {31'd0, busy}, {31'd0, exp_b});
        chk("done", {31'd0, done}, {31'd0, exp_d});
    endtask

    task automatic start_burst(input logic ud, input logic [3:0] pat, input logic [3:0] r);
        start = 1'b1; use_def = ud; pattern = pat; rep = r;
        tick();
        start = 1'b0; pattern = ~pat; use_def = ~ud; rep = ~r;
    endtask

    task automatic capture(input int n, output logic [31:0] bits, output logic allv);
        bits = 32'd0; allv = 1'b1;
        for (int i = 0; i < n; i++) begin
            bits = {bits[30:0], q};
            allv = allv & valid & busy & ~done;
            tick();
        end
    endtask

    logic [31:0] cap;
    logic        allv;
    int          dcount;

    initial begin
        rst = 1'b0;
        tick(); tick();
        chk("reset_outs", {28'd0, q, valid, busy, done}, 32'd0);
        rst = 1'b1;
        tick();

        // Default pattern, single frame
        start_burst(1'b1, 4'b0000, 4'd0);
        capture(FL, cap, allv);
`ifdef SEQGEN_PARITY_EN
        chk("def_stream", cap, 32'b10111);
`else
        chk("def_stream", cap, 32'b1011);
`endif
        chk("def_valid", {31'd0, allv}, 32'd1);
        chk("def_done", {30'd0, done, busy}, 32'b10);
        tick();
        chk("def_done_pulse", {31'd0, done}, 32'd0);

        // User pattern repeated three times
        start_burst(1'b0, 4'b1100, 4'd2);
        capture(3 * FL, cap, allv);
`ifdef SEQGEN_PARITY_EN
        chk("rep_stream", cap, 32'b110001100011000);
`else
        chk("rep_stream", cap, 32'b110011001100);
`endif
        chk("rep_valid", {31'd0, allv}, 32'd1);
        chk("rep_done", {31'd0, done}, 32'd1);
        tick();

        // Abort on the 6th valid cycle of a long burst
        start_burst(1'b1, 4'b0000, 4'd15);
        for (int i = 0; i < 5; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_outs", {29'd0, valid, busy, done}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 32'd0);

        // Start and abort together in IDLE
        start = 1'b1; abort = 1'b1; use_def = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {31'd0, valid}, 32'd0);

        // Start pulses while busy are ignored
        start_burst(1'b0, 4'b0110, 4'd1);
        start = 1'b1; use_def = 1'b1;
        capture(2 * FL - 1, cap, allv);
        start = 1'b0;
`ifdef SEQGEN_PARITY_EN
        chk("ign_stream", cap, 32'b011000110);
`else
        chk("ign_stream", cap, 32'b0110011);
`endif
        tick();
        tick();

        // Start held through DONE: new burst right after the done cycle
        start = 1'b1; use_def = 1'b1; rep = 4'd0;
        tick();
        for (int i = 0; i < FL; i++) tick();
        chk("b2b_done", {29'd0, done, valid, busy}, 32'b100);
        tick();
        start = 1'b0;
        chk("b2b_msb", {28'd0, done, valid, busy, q}, 32'b0111);
        tick();

        // Reset mid-frame
        rst = 1'b0;
        tick();
        chk("midrst_outs", {28'd0, q, valid, busy, done}, 32'd0);
        rst = 1'b1;
        start_burst(1'b1, 4'b0000, 4'd0);
        chk("post_rst_start", {30'd0, valid, q}, 32'b11);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 299) != 0);
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 39) == 0);
            use_def = $urandom_range(0, 1) == 1;
            pattern = 4'($urandom_range(0, 15));
            rep     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
